// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message padder.
// The state enum and word-index constants are used by the padder and its tail-merge helper.
package sha256_pkg;

  typedef enum logic [2:0] {
    FILL,
    PAD,
    LEN,
    ISSUE,
    WAIT
  } state_t;

  localparam logic [31:0] SHA256_PAD_WORD    = 32'h8000_0000;
  localparam int unsigned SHA256_BLK_WORDS   = 16;
  localparam logic [3:0]  SHA256_LEN_WORD_HI = 4'd14;
  localparam logic [3:0]  SHA256_LAST_WORD   = 4'(SHA256_BLK_WORDS - 1);

endpackage

// File: rtl/sha256_tail_merge.sv
// Combinational byte masking for a message word, plus 0x80 marker insertion after the data bytes.
// Zero latency; no flow control of its own.
module sha256_tail_merge
  import sha256_pkg::*;
(
  input  logic [31:0] data,
  input  logic [2:0]  bytes,
  output logic [31:0] masked,
  output logic [31:0] merged,
  output logic        marker_placed
);

  logic [31:0] mask;
  logic [31:0] mark;

  always_comb begin
    mask = 32'hFFFF_FFFF;
    mark = 32'h0000_0000;
    case (bytes)
      3'd0: begin mask = 32'h0000_0000; mark = SHA256_PAD_WORD;       end
      3'd1: begin mask = 32'hFF00_0000; mark = SHA256_PAD_WORD >> 8;  end
      3'd2: begin mask = 32'hFFFF_0000; mark = SHA256_PAD_WORD >> 16; end
      3'd3: begin mask = 32'hFFFF_FF00; mark = SHA256_PAD_WORD >> 24; end
      default: ;
    endcase
  end

  assign masked        = data & mask;
  assign merged        = masked | mark;
  assign marker_placed = (bytes < 3'd4);

endmodule

// File: rtl/sha256_msg_padder.sv
// Builds padded 512-bit SHA-256 blocks from a byte-granular word stream and hands them to the core.
// s_ready drops outside FILL; each issued block is held stable until the core raises blk_done.
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [31:0]  s_data,
  input  logic [2:0]   s_bytes,
  input  logic         s_last,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [511:0] blk_data,
  output logic         blk_start,
  output logic         blk_first,
  output logic         blk_last,
  input  logic         blk_done,
  output logic         msg_busy,
  output logic         msg_done
);

  state_t                                 state_q, state_d;
  logic [3:0]                             widx_q, widx_d;
  logic [LEN_W-1:0]                       bitlen_q, bitlen_d;
  logic [SHA256_BLK_WORDS-1:0][31:0]      buf_q, buf_d;
  logic                                   marker_q, marker_d;
  logic                                   pend_q, pend_d;
  logic                                   first_q, first_d;
  logic                                   last_q, last_d;
  logic                                   busy_q, busy_d;
  logic                                   done_q, done_d;

  logic [31:0] masked_w;
  logic [31:0] merged_w;
  logic        marker_w;
  logic [63:0] len64;

  sha256_tail_merge u_tail_merge (
    .data          (s_data),
    .bytes         (s_bytes),
    .masked        (masked_w),
    .merged        (merged_w),
    .marker_placed (marker_w)
  );

  assign len64 = 64'(bitlen_q);

  always_comb begin
    state_d   = state_q;
    widx_d    = widx_q;
    bitlen_d  = bitlen_q;
    buf_d     = buf_q;
    marker_d  = marker_q;
    pend_d    = pend_q;
    first_d   = first_q;
    last_d    = last_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    s_ready   = 1'b0;
    blk_start = 1'b0;

    case (state_q)
      FILL: begin
        s_ready = 1'b1;
        if (s_valid) begin
          buf_d[widx_q] = s_last ? merged_w : masked_w;
          bitlen_d      = bitlen_q + LEN_W'({s_bytes, 3'b000});
          widx_d        = widx_q + 4'd1;
          if (!busy_q) begin
            busy_d  = 1'b1;
            first_d = 1'b1;
          end
          if (s_last) begin
            marker_d = marker_w;
            // A last word in slot 15 fills the block; padding continues in a fresh block.
            if (widx_q == SHA256_LAST_WORD) begin
              pend_d  = 1'b1;
              state_d = ISSUE;
            end else if (widx_d == SHA256_LEN_WORD_HI && marker_w) begin
              state_d = LEN;
            end else begin
              state_d = PAD;
            end
          end else if (widx_q == SHA256_LAST_WORD) begin
            state_d = ISSUE;
          end
        end
      end

      PAD: begin
        buf_d[widx_q] = marker_q ? 32'h0 : SHA256_PAD_WORD;
        marker_d      = 1'b1;
        widx_d        = widx_q + 4'd1;
        if (widx_q == SHA256_LEN_WORD_HI - 4'd1) begin
          state_d = LEN;
        end else if (widx_q == SHA256_LAST_WORD) begin
          pend_d  = 1'b1;
          state_d = ISSUE;
        end
      end

      LEN: begin
        buf_d[SHA256_LEN_WORD_HI]      = len64[63:32];
        buf_d[SHA256_LEN_WORD_HI + 1]  = len64[31:0];
        last_d  = 1'b1;
        state_d = ISSUE;
      end

      ISSUE: begin
        blk_start = 1'b1;
        state_d   = WAIT;
      end

      WAIT: begin
        if (blk_done) begin
          widx_d  = 4'd0;
          buf_d   = '0;
          first_d = 1'b0;
          if (last_q) begin
            done_d   = 1'b1;
            busy_d   = 1'b0;
            bitlen_d = '0;
            last_d   = 1'b0;
            marker_d = 1'b0;
            pend_d   = 1'b0;
            state_d  = FILL;
          end else if (pend_q) begin
            pend_d  = 1'b0;
            state_d = PAD;
          end else begin
            state_d = FILL;
          end
        end
      end

      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= FILL;
      widx_q   <= '0;
      bitlen_q <= '0;
      buf_q    <= '0;
      marker_q <= 1'b0;
      pend_q   <= 1'b0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      widx_q   <= widx_d;
      bitlen_q <= bitlen_d;
      buf_q    <= buf_d;
      marker_q <= marker_d;
      pend_q   <= pend_d;
      first_q  <= first_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign blk_data  = buf_q;
  assign blk_first = first_q && (state_q == ISSUE || state_q == WAIT);
  assign blk_last  = last_q;
  assign msg_busy  = busy_q;
  assign msg_done  = done_q;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Bench for sha256_msg_padder: byte-level padding model feeds a block scoreboard,
// and a behavioural SHA-256 core hashes the issued blocks for known-answer digests.
module tb_sha256_msg_padder;

  logic         clk;
  logic         reset_n;
  logic [31:0]  s_data;
  logic [2:0]   s_bytes;
  logic         s_last;
  logic         s_valid;
  logic         s_ready;
  logic [511:0] blk_data;
  logic         blk_start;
  logic         blk_first;
  logic         blk_last;
  logic         blk_done;
  logic         msg_busy;
  logic         msg_done;

  sha256_msg_padder #(.LEN_W(64)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .s_data    (s_data),
    .s_bytes   (s_bytes),
    .s_last    (s_last),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .blk_data  (blk_data),
    .blk_start (blk_start),
    .blk_first (blk_first),
    .blk_last  (blk_last),
    .blk_done  (blk_done),
    .msg_busy  (msg_busy),
    .msg_done  (msg_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [511:0] dat;
    logic         first;
    logic         last;
  } exp_t;

  exp_t         exp_q [$];
  logic [511:0] seen_q [$];
  logic [255:0] cur_h;
  logic [255:0] digest;
  int           core_lat;
  int           n_err;
  int           n_chk;

  logic [31:0] k_tab [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic [255:0] sha_iv = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
    for (int i = 0; i < 16; i++) w[i] = blk[32*i +: 32];
    for (int i = 16; i < 64; i++)
      w[i] = w[i-16] + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-7]
           + (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10));
    {a, b, c, d, e, f, g, hh} = hin;
    for (int i = 0; i < 64; i++) begin
      t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + k_tab[i] + w[i];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + hh};
  endfunction

  // Reference padding at byte level, split into expected blocks.
  task automatic push_model(input byte unsigned m[$]);
    byte unsigned p[$];
    logic [63:0]  bl;
    int           nb;
    exp_t         ex;
    p  = m;
    bl = 64'(m.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
    nb = p.size() / 64;
    for (int b = 0; b < nb; b++) begin
      ex.dat = '0;
      for (int i = 0; i < 16; i++)
        ex.dat[32*i +: 32] = {p[64*b+4*i], p[64*b+4*i+1], p[64*b+4*i+2], p[64*b+4*i+3]};
      ex.first = (b == 0);
      ex.last  = (b == nb - 1);
      exp_q.push_back(ex);
    end
  endtask

  task automatic send_word(input logic [31:0] d, input logic [2:0] nb, input logic last);
    int guard;
    guard   = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_bytes = nb;
    s_last  = last;
    while (!s_ready && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 3000) check("s_ready_timeout", 1, 0);
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_msg(input byte unsigned m[$], input bit empty_tail);
    int          n, nfull, rem;
    logic [31:0] d;
    push_model(m);
    n     = m.size();
    nfull = n / 4;
    rem   = n % 4;
    for (int w = 0; w < nfull; w++)
      send_word({m[4*w], m[4*w+1], m[4*w+2], m[4*w+3]}, 3'd4,
                (rem == 0 && !empty_tail && w == nfull - 1));
    if (rem != 0 || empty_tail || n == 0) begin
      d = $urandom;  // junk in the unused bytes must be masked off
      for (int j = 0; j < rem; j++) d[31-8*j -: 8] = m[4*nfull+j];
      send_word(d, 3'(rem), 1'b1);
    end
  endtask

  task automatic wait_done();
    int g;
    g = 0;
    while (!msg_done && g < 5000) begin
      @(negedge clk);
      g++;
    end
    check("msg_done_seen", (g < 5000), 1);
  endtask

  task automatic wait_start_lat(output int lat);
    lat = 0;
    while (!blk_start && lat < 300) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_s_ready",   s_ready,   1);
    check("rst_blk_start", blk_start, 0);
    check("rst_blk_first", blk_first, 0);
    check("rst_blk_last",  blk_last,  0);
    check("rst_msg_busy",  msg_busy,  0);
    check("rst_msg_done",  msg_done,  0);
    check("rst_blk_data",  blk_data,  0);
  endtask

  // Behavioural compression core: checks each block, hashes it, holds, then acks.
  initial begin : core_model
    exp_t         ex;
    logic [511:0] snap;
    int           bad;
    blk_done = 1'b0;
    cur_h    = '0;
    forever begin
      @(negedge clk);
      if (reset_n && blk_start) begin
        if (exp_q.size() == 0) begin
          check("blk_unexpected", 1, 0);
          ex.dat = '0; ex.first = 1'b0; ex.last = 1'b0;
        end else begin
          ex = exp_q.pop_front();
        end
        check("blk_data",  blk_data,  ex.dat);
        check("blk_first", blk_first, ex.first);
        check("blk_last",  blk_last,  ex.last);
        seen_q.push_back(blk_data);
        cur_h = sha_compress(blk_first ? sha_iv : cur_h, blk_data);
        snap  = blk_data;
        bad   = 0;
        for (int i = 0; i < core_lat; i++) begin
          @(negedge clk);
          if (blk_data !== snap || s_ready !== 1'b0 || blk_start !== 1'b0 ||
              blk_first !== ex.first || blk_last !== ex.last) bad++;
        end
        check("wait_hold", bad, 0);
        blk_done = 1'b1;
        @(negedge clk);
        blk_done = 1'b0;
        check("msg_done_pulse", msg_done, ex.last);
        if (ex.last) begin
          check("busy_clear", msg_busy, 0);
          digest = cur_h;
        end
      end
    end
  end

  initial begin : stim
    byte unsigned msg [$];
    int           lat;
    int           lens [12] = '{1, 2, 5, 52, 57, 60, 61, 63, 64, 100, 119, 128};
    logic [255:0] dig_empty = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    logic [255:0] dig_abc   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;

    n_err = 0; n_chk = 0;
    reset_n = 1'b0; s_valid = 1'b0; s_data = '0; s_bytes = '0; s_last = 1'b0;
    core_lat = 3; digest = '0;
    #3;
    check_reset_outputs();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Empty message
    msg.delete();
    seen_q.delete();
    send_msg(msg, 1'b0);
    wait_done();
    check("digest_empty", digest, dig_empty);
    check("empty_word0", seen_q[0][31:0], 32'h8000_0000);

    // "abc": single block, latency from last accept
    msg = '{8'h61, 8'h62, 8'h63};
    seen_q.delete();
    digest = '0;
    send_msg(msg, 1'b0);
    check("busy_set", msg_busy, 1);
    wait_start_lat(lat);
    check("lat_abc", lat, 14);
    wait_done();
    check("digest_abc", digest, dig_abc);
    check("abc_word0",  seen_q[0][31:0],    32'h6162_6380);
    check("abc_word15", seen_q[0][511:480], 32'h0000_0018);

    // 55 bytes: marker lands in word 13, length written straight away
    msg.delete();
    for (int i = 0; i < 55; i++) msg.push_back(8'($urandom_range(0, 255)));
    seen_q.delete();
    send_msg(msg, 1'b0);
    wait_start_lat(lat);
    check("lat_55", lat, 1);
    wait_done();
    check("blocks_55", seen_q.size(), 1);

    // 56 bytes: marker spills into a second block
    msg.delete();
    for (int i = 0; i < 56; i++) msg.push_back(8'($urandom_range(0, 255)));
    seen_q.delete();
    send_msg(msg, 1'b0);
    wait_done();
    check("blocks_56", seen_q.size(), 2);
    check("b56_blk1_w14", seen_q[0][479:448], 32'h8000_0000);
    check("b56_blk1_w15", seen_q[0][511:480], 32'h0);
    check("b56_blk2_w15", seen_q[1][511:480], 32'h0000_01C0);

    // 64 bytes: first block is pure data
    msg.delete();
    for (int i = 0; i < 64; i++) msg.push_back(8'($urandom_range(0, 255)));
    seen_q.delete();
    send_msg(msg, 1'b0);
    wait_done();
    check("blocks_64", seen_q.size(), 2);
    check("b64_blk2_w0",  seen_q[1][31:0],    32'h8000_0000);
    check("b64_blk2_w15", seen_q[1][511:480], 32'h0000_0200);

    // Assorted lengths, some ending with an empty tail word
    for (int k = 0; k < 12; k++) begin
      msg.delete();
      for (int i = 0; i < lens[k]; i++) msg.push_back(8'($urandom_range(0, 255)));
      seen_q.delete();
      send_msg(msg, (lens[k] % 8 == 0));
      wait_done();
      check("blocks_len", seen_q.size(), (lens[k] + 9 + 63) / 64);
    end

    // Slow core: block must stay frozen for the whole wait
    core_lat = 100;
    msg.delete();
    for (int i = 0; i < 70; i++) msg.push_back(8'($urandom_range(0, 255)));
    send_msg(msg, 1'b0);
    wait_done();
    core_lat = 3;

    // Reset while padding the second block of a 64-byte message
    msg.delete();
    for (int i = 0; i < 64; i++) msg.push_back(8'($urandom_range(0, 255)));
    send_msg(msg, 1'b0);
    wait_start_lat(lat);
    repeat (8) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset_outputs();
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    msg = '{8'h61, 8'h62, 8'h63};
    digest = '0;
    send_msg(msg, 1'b0);
    wait_done();
    check("digest_abc_after_rst", digest, dig_abc);

    repeat (3) @(negedge clk);
    check("sb_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sha256_msg_padder.md
Name: sha256_msg_padder

Overview:
Initiator side of the SHA-256 block interface. Accepts a byte-granular message as a stream of 32-bit words and builds each 512-bit block, appending FIPS 180-4 padding (0x80, zeros, 64-bit big-endian bit length). Presents each block to the compression core with a start pulse and waits for its done before building the next block. Sits between the host/miner front end and the compression core.

Parameters:
LEN_W, 64, width of the message bit-length counter; zero-extended to 64 bits in the length field.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
s_data  in  32  message word; first byte in [31:24]
s_bytes  in  3  valid bytes in s_data, 1..4; 0 is legal only with s_last (empty tail)
s_last  in  1  final word of message
s_valid  in  1  word valid
s_ready  out  1  padder can accept a word this cycle
blk_data  out  512  block to core; word i at [32*i+31 : 32*i] (word 0 at [31:0])
blk_start  out  1  one-cycle pulse, block valid
blk_first  out  1  block is first of message; valid with blk_start, held until done
blk_last  out  1  block is final of message; same timing as blk_first
blk_done  in  1  core finished current block (level)
msg_busy  out  1  message in progress (first accepted word to msg_done)
msg_done  out  1  one-cycle pulse after the last block's blk_done

Behaviour:
- Reset: FSM=FILL, widx=0, bitlen=0, buffer=0, s_ready=1, blk_start=0, blk_first=0, blk_last=0, msg_busy=0, msg_done=0. Reset mid-block drops the message; core is not notified.
- States: FILL, PAD, LEN, ISSUE, WAIT.
- FILL: s_ready=1. A word is accepted when s_valid&&s_ready. Accepted bytes are stored at buffer word widx, left-justified; unused low bytes are zeroed. bitlen += 8*s_bytes (wraps mod 2^LEN_W). widx increments.
  - Non-last word at widx=15 -> ISSUE.
  - Last word with s_bytes<4: the 0x80 byte is placed directly after the data bytes in the same word; pad_marker_done=1.
  - Last word with s_bytes=4: pad_marker_done=0.
  - After a last word -> PAD.
- PAD: s_ready=0. Writes one word per cycle at widx: 0x80000000 if !pad_marker_done (then set it), else 0.
  - When widx reaches 14 with the marker written -> LEN.
  - If widx wraps past 15 before that (tail >55 bytes): ISSUE with blk_last=0. Set pad_pending; after WAIT return to PAD at widx=0.
  - Special case: widx=14 exactly on the PAD entry cycle with the marker already written -> LEN immediately.
- LEN: writes bitlen[63:32] to word 14 and bitlen[31:0] to word 15 in one cycle. Sets blk_last=1 -> ISSUE.
- ISSUE: blk_start=1 for exactly one cycle; blk_first=1 if this is the first block since the message began. -> WAIT.
- WAIT: blk_data, blk_first and blk_last are held stable, since the core samples words over its first 16 cycles. The core drops done at the start edge, so the first WAIT cycle already sees the new done state. On blk_done=1:
  - widx=0 and the buffer is cleared.
  - If blk_last: msg_done pulse, msg_busy=0, bitlen=0 -> FILL.
  - Else if pad_pending -> PAD.
  - Else -> FILL.
- blk_done outside WAIT is ignored. s_valid outside FILL is not accepted (s_ready=0).
- Latency: last word accepted at cycle T with widx=k after write -> blk_start at T + (14-k) + 2 for single-block tails.

Decomposition:
- Shared package sha256_pkg:
  - state enum (FILL, PAD, LEN, ISSUE, WAIT)
  - SHA256_PAD_WORD = 32'h80000000
  - SHA256_BLK_WORDS = 16
  - SHA256_LEN_WORD_HI = 14
- One sub-module, sha256_tail_merge: combinational byte-mask/marker insertion for a last word, given s_data and s_bytes. Everything else stays in this module.

Test Plan:
- Empty message (s_bytes=0, s_last=1) -> one block: word0=0x80000000, words1..15=0, blk_first=blk_last=1; feeding the core yields e3b0c442...b855.
- "abc" (one word 0x61626300, s_bytes=3, s_last) -> word0=0x61626380, word15=0x00000018; core digest ba7816bf...f20015ad; msg_done one cycle after blk_done.
- 56-byte message (14 words, last s_bytes=4) -> two blocks. Block1 word14=0x80000000, word15=0, blk_last=0. Block2 words0..13=0, word15=0x000001C0, blk_first=0, blk_last=1.
- 64-byte message -> block1 holds data only, issued on the 16th accept. Block2 word0=0x80000000, word15=0x00000200.
- Backpressure: hold blk_done=0 for 100 cycles -> s_ready=0 and blk_data unchanged throughout; blk_start never re-pulses.
- Assert reset_n mid-PAD of a second block -> all outputs at reset values immediately; a fresh "abc" afterwards hashes correctly.
